// File: rtl/spi_responder.sv
`timescale 1ns/1ps
// SPI mode-0 register-file responder: 16-bit {rw, addr[6:0], data[7:0]} frames,
// oversampled in the i_clock domain, with a local write port and combinational readback.
module spi_responder #(
    parameter int NUM_REGS   = 16,
    parameter int WORD_WIDTH = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  SCLK,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  o_miso_oe,
    input  logic                  i_local_we,
    input  logic [6:0]            i_local_addr,
    input  logic [WORD_WIDTH-1:0] i_local_data,
    input  logic [6:0]            i_rd_addr,
    output logic [WORD_WIDTH-1:0] o_rd_data,
    output logic                  o_wr_strobe,
    output logic [6:0]            o_wr_addr,
    output logic [WORD_WIDTH-1:0] o_wr_data,
    output logic                  o_frame_done,
    output logic                  o_frame_error,
    output logic                  o_busy
);
    // state  | meaning
    // S_IDLE | waiting for CS fall while enabled
    // S_ADDR | shifting in rw + address (edges 1..8)
    // S_DATA | shifting in data, shifting out read data (edges 9..16)
    // S_END  | all 16 bits seen, waiting for CS rise; extra edges mark overrun
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_END} state_t;

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    function automatic logic in_range(input logic [6:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    logic [1:0] rst_pipe;
    logic       rst;
    logic [2:0] sclk_s, cs_s, mosi_s;
    logic       sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_bit;

    state_t                state, state_n;
    logic [4:0]            bit_cnt;
    logic [WORD_WIDTH-1:0] shift_q, tx_q;
    logic [6:0]            addr_q, hdr_addr;
    logic                  cmd_rd, ovr;
    logic                  start, shift_en, latch_hdr, tx_shift, set_ovr;
    logic                  commit, done_n, err_n;
    logic [WORD_WIDTH-1:0] regs [NUM_REGS];

    // Reset asserts immediately, releases on a clock edge.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) rst_pipe <= 2'b11;
        else         rst_pipe <= {rst_pipe[0], 1'b0};
    end
    assign rst = rst_pipe[1];

    // CS chain resets low so a CS already low at reset release never looks like a falling edge.
    always_ff @(posedge i_clock or posedge rst) begin
        if (rst) begin
            sclk_s <= '0;
            cs_s   <= '0;
            mosi_s <= '0;
        end else begin
            sclk_s <= {sclk_s[1:0], SCLK};
            cs_s   <= {cs_s[1:0], CS};
            mosi_s <= {mosi_s[1:0], MOSI};
        end
    end

    assign sclk_rise = sclk_s[1] & ~sclk_s[2];
    assign sclk_fall = ~sclk_s[1] & sclk_s[2];
    assign cs_rise   = cs_s[1] & ~cs_s[2];
    assign cs_fall   = ~cs_s[1] & cs_s[2];
    assign mosi_bit  = mosi_s[2];
    assign hdr_addr  = {shift_q[5:0], mosi_bit};

    always_comb begin
        state_n   = state;
        start     = 1'b0;
        shift_en  = 1'b0;
        latch_hdr = 1'b0;
        tx_shift  = 1'b0;
        set_ovr   = 1'b0;
        commit    = 1'b0;
        done_n    = 1'b0;
        err_n     = 1'b0;
        case (state)
            S_IDLE: if (cs_fall && i_enable) begin
                start   = 1'b1;
                state_n = S_ADDR;
            end
            S_ADDR: if (cs_rise) begin
                err_n   = 1'b1;
                state_n = S_IDLE;
            end else if (sclk_rise) begin
                shift_en = 1'b1;
                if (bit_cnt == 5'd7) begin
                    latch_hdr = 1'b1;
                    state_n   = S_DATA;
                end
            end
            S_DATA: if (cs_rise) begin
                err_n   = 1'b1;
                state_n = S_IDLE;
            end else begin
                if (sclk_rise) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 5'd15) state_n = S_END;
                end
                // The falling edge right after edge 8 must keep bit 7 on the line.
                if (sclk_fall && cmd_rd && bit_cnt >= 5'd9) tx_shift = 1'b1;
            end
            S_END: if (cs_rise) begin
                state_n = S_IDLE;
                if (ovr) begin
                    err_n = 1'b1;
                end else begin
                    done_n = 1'b1;
                    commit = !cmd_rd && in_range(addr_q);
                end
            end else if (sclk_rise) begin
                set_ovr = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            o_wr_strobe   <= 1'b0;
            o_frame_done  <= 1'b0;
            o_frame_error <= 1'b0;
            o_wr_addr     <= '0;
            o_wr_data     <= '0;
        end else begin
            state         <= state_n;
            o_wr_strobe   <= commit;
            o_frame_done  <= done_n;
            o_frame_error <= err_n;
            if (commit) begin
                o_wr_addr <= addr_q;
                o_wr_data <= shift_q;
            end
        end
    end

    always_ff @(posedge i_clock or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            shift_q <= '0;
            tx_q    <= '0;
            addr_q  <= '0;
            cmd_rd  <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            if (start) begin
                bit_cnt <= '0;
                shift_q <= '0;
                ovr     <= 1'b0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 5'd1;
                shift_q <= latch_hdr ? '0 : {shift_q[WORD_WIDTH-2:0], mosi_bit};
            end
            if (latch_hdr) begin
                cmd_rd <= shift_q[6];
                addr_q <= hdr_addr;
                tx_q   <= in_range(hdr_addr) ? regs[hdr_addr[IW-1:0]] : '0;
            end else if (tx_shift) begin
                tx_q <= {tx_q[WORD_WIDTH-2:0], 1'b0};
            end
            if (set_ovr) ovr <= 1'b1;
        end
    end

    // SPI commit has priority over a same-cycle local write.
    always_ff @(posedge i_clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit) begin
            regs[addr_q[IW-1:0]] <= shift_q;
        end else if (i_local_we && in_range(i_local_addr)) begin
            regs[i_local_addr[IW-1:0]] <= i_local_data;
        end
    end

    assign o_rd_data = in_range(i_rd_addr) ? regs[i_rd_addr[IW-1:0]] : '0;
    assign MISO      = (state == S_DATA) && cmd_rd && tx_q[WORD_WIDTH-1];
    assign o_miso_oe = (state != S_IDLE);
    assign o_busy    = (state != S_IDLE);
endmodule

// File: tb/tb_spi_responder.sv
`timescale 1ns/1ps
// Directed bench for spi_responder: 50 MHz system clock, 1 MHz SPI mode-0 master model.
module tb_spi_responder;
    localparam int HALF = 25;

    logic       i_clock = 1'b0, i_reset = 1'b1, i_enable = 1'b1;
    logic       SCLK = 1'b0, CS = 1'b1, MOSI = 1'b0;
    logic       MISO, o_miso_oe;
    logic       i_local_we = 1'b0;
    logic [6:0] i_local_addr = '0;
    logic [7:0] i_local_data = '0;
    logic [6:0] i_rd_addr = '0;
    logic [7:0] o_rd_data;
    logic       o_wr_strobe, o_frame_done, o_frame_error, o_busy;
    logic [6:0] o_wr_addr;
    logic [7:0] o_wr_data;

    int n_cmp = 0, n_bad = 0;
    int cnt_strobe = 0, cnt_done = 0, cnt_err = 0;
    int s_strobe, s_done, s_err;
    logic [15:0] f_rx;
    bit f_oe, f_busy_mid, f_busy_at_done;
    int f_lat;

    spi_responder #(.NUM_REGS(16), .WORD_WIDTH(8)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable),
        .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO), .o_miso_oe(o_miso_oe),
        .i_local_we(i_local_we), .i_local_addr(i_local_addr), .i_local_data(i_local_data),
        .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
        .o_wr_strobe(o_wr_strobe), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_frame_done(o_frame_done), .o_frame_error(o_frame_error), .o_busy(o_busy)
    );

    always #10 i_clock = ~i_clock;

    always @(negedge i_clock) begin
        if (o_wr_strobe === 1'b1) cnt_strobe++;
        if (o_frame_done === 1'b1) cnt_done++;
        if (o_frame_error === 1'b1) cnt_err++;
    end

    task automatic snap();
        s_strobe = cnt_strobe;
        s_done   = cnt_done;
        s_err    = cnt_err;
    endtask

    task automatic peek(input logic [6:0] a);
        i_rd_addr = a;
        #1;
    endtask

    // One CS-framed transfer of nedges clocks; optional local write aimed at the commit cycle.
    task automatic spi_frame(input logic [15:0] word, input int nedges, input bit collide,
                             input logic [6:0] la, input logic [7:0] ld);
        f_rx = '0;
        f_oe = 1'b0;
        f_busy_mid = 1'b0;
        f_busy_at_done = 1'b1;
        f_lat = 0;
        snap();
        CS = 1'b0;
        for (int i = 0; i < nedges; i++) begin
            MOSI = (i < 16) ? word[15-i] : 1'b0;
            repeat (HALF) @(negedge i_clock);
            f_rx = {f_rx[14:0], MISO};
            f_oe = f_oe | o_miso_oe;
            if (i == 0) f_busy_mid = o_busy;
            SCLK = 1'b1;
            repeat (HALF) @(negedge i_clock);
            SCLK = 1'b0;
        end
        repeat (HALF) @(negedge i_clock);
        CS = 1'b1;
        MOSI = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge i_clock);
            if (collide && k == 2) begin
                i_local_we = 1'b1;
                i_local_addr = la;
                i_local_data = ld;
            end else if (k == 3) begin
                i_local_we = 1'b0;
            end
            if (f_lat == 0 && (o_frame_done || o_frame_error)) begin
                f_lat = k;
                f_busy_at_done = o_busy;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge i_clock);
        peek(7'h00);
        n_cmp++; if (MISO !== 1'b0) begin n_bad++; $display("FAIL reset_miso: got %b want 0", MISO); end
        n_cmp++; if (o_miso_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe: got %b want 0", o_miso_oe); end
        n_cmp++; if ({o_wr_strobe, o_frame_done, o_frame_error} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b want 000", {o_wr_strobe, o_frame_done, o_frame_error}); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_cmp++; if ({o_wr_addr, o_wr_data} !== 15'h0) begin n_bad++; $display("FAIL reset_wr: got %h/%h want 00/00", o_wr_addr, o_wr_data); end
        n_cmp++; if (o_rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_reg0: got %h want 00", o_rd_data); end
        @(negedge i_clock);
        i_reset = 1'b0;
        repeat (10) @(negedge i_clock);
    endtask

    task automatic test_write();
        spi_frame(16'h0A5C, 16, 1'b0, 7'h0, 8'h0);
        peek(7'h0A);
        n_cmp++; if (cnt_strobe - s_strobe !== 1) begin n_bad++; $display("FAIL wr_strobe_count: got %0d want 1", cnt_strobe - s_strobe); end
        n_cmp++; if (cnt_done - s_done !== 1) begin n_bad++; $display("FAIL wr_done_count: got %0d want 1", cnt_done - s_done); end
        n_cmp++; if (cnt_err - s_err !== 0) begin n_bad++; $display("FAIL wr_err_count: got %0d want 0", cnt_err - s_err); end
        n_cmp++; if (f_lat !== 3) begin n_bad++; $display("FAIL wr_done_latency: got %0d want 3", f_lat); end
        n_cmp++; if (f_busy_mid !== 1'b1) begin n_bad++; $display("FAIL wr_busy_mid: got %b want 1", f_busy_mid); end
        n_cmp++; if (f_busy_at_done !== 1'b0) begin n_bad++; $display("FAIL wr_busy_at_done: got %b want 0", f_busy_at_done); end
        n_cmp++; if (o_wr_addr !== 7'h0A || o_wr_data !== 8'h5C) begin n_bad++; $display("FAIL wr_addr_data: got %h/%h want 0a/5c", o_wr_addr, o_wr_data); end
        n_cmp++; if (o_rd_data !== 8'h5C) begin n_bad++; $display("FAIL wr_reg0a: got %h want 5c", o_rd_data); end
        n_cmp++; if (f_rx !== 16'h0000) begin n_bad++; $display("FAIL wr_miso_quiet: got %h want 0000", f_rx); end
    endtask

    task automatic test_readback();
        spi_frame(16'h8A00, 16, 1'b0, 7'h0, 8'h0);
        n_cmp++; if (f_rx !== 16'h005C) begin n_bad++; $display("FAIL rd_miso: got %h want 005c", f_rx); end
        n_cmp++; if (cnt_done - s_done !== 1) begin n_bad++; $display("FAIL rd_done_count: got %0d want 1", cnt_done - s_done); end
        n_cmp++; if (cnt_strobe - s_strobe !== 0) begin n_bad++; $display("FAIL rd_no_strobe: got %0d want 0", cnt_strobe - s_strobe); end
        n_cmp++; if (f_oe !== 1'b1) begin n_bad++; $display("FAIL rd_oe: got %b want 1", f_oe); end
    endtask

    task automatic test_out_of_range();
        spi_frame(16'h7F11, 16, 1'b0, 7'h0, 8'h0);
        peek(7'h7F);
        n_cmp++; if (cnt_done - s_done !== 1) begin n_bad++; $display("FAIL oor_done_count: got %0d want 1", cnt_done - s_done); end
        n_cmp++; if (cnt_strobe - s_strobe !== 0) begin n_bad++; $display("FAIL oor_no_strobe: got %0d want 0", cnt_strobe - s_strobe); end
        n_cmp++; if (o_wr_addr !== 7'h0A || o_wr_data !== 8'h5C) begin n_bad++; $display("FAIL oor_last_wr: got %h/%h want 0a/5c", o_wr_addr, o_wr_data); end
        n_cmp++; if (o_rd_data !== 8'h00) begin n_bad++; $display("FAIL oor_rd_data: got %h want 00", o_rd_data); end
        spi_frame(16'hFF00, 16, 1'b0, 7'h0, 8'h0);
        n_cmp++; if (f_rx !== 16'h0000) begin n_bad++; $display("FAIL oor_read_miso: got %h want 0000", f_rx); end
        n_cmp++; if (cnt_done - s_done !== 1) begin n_bad++; $display("FAIL oor_read_done: got %0d want 1", cnt_done - s_done); end
    endtask

    task automatic test_abort();
        spi_frame(16'h0333, 11, 1'b0, 7'h0, 8'h0);
        peek(7'h03);
        n_cmp++; if (cnt_err - s_err !== 1) begin n_bad++; $display("FAIL abort_err: got %0d want 1", cnt_err - s_err); end
        n_cmp++; if (cnt_done - s_done + cnt_strobe - s_strobe !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", cnt_done - s_done + cnt_strobe - s_strobe); end
        n_cmp++; if (o_rd_data !== 8'h00) begin n_bad++; $display("FAIL abort_reg03: got %h want 00", o_rd_data); end
        spi_frame(16'h0444, 17, 1'b0, 7'h0, 8'h0);
        peek(7'h04);
        n_cmp++; if (cnt_err - s_err !== 1) begin n_bad++; $display("FAIL ovr_err: got %0d want 1", cnt_err - s_err); end
        n_cmp++; if (cnt_strobe - s_strobe !== 0 || cnt_done - s_done !== 0) begin n_bad++; $display("FAIL ovr_no_write: got strobe %0d done %0d want 0 0", cnt_strobe - s_strobe, cnt_done - s_done); end
        n_cmp++; if (o_rd_data !== 8'h00) begin n_bad++; $display("FAIL ovr_reg04: got %h want 00", o_rd_data); end
    endtask

    task automatic test_collision();
        spi_frame(16'h0555, 16, 1'b1, 7'h05, 8'hAA);
        peek(7'h05);
        n_cmp++; if (cnt_strobe - s_strobe !== 1) begin n_bad++; $display("FAIL coll_strobe: got %0d want 1", cnt_strobe - s_strobe); end
        n_cmp++; if (o_rd_data !== 8'h55) begin n_bad++; $display("FAIL coll_reg05: got %h want 55", o_rd_data); end
        @(negedge i_clock);
        i_local_we = 1'b1; i_local_addr = 7'h05; i_local_data = 8'hC3;
        @(negedge i_clock);
        i_local_we = 1'b0;
        peek(7'h05);
        n_cmp++; if (o_rd_data !== 8'hC3) begin n_bad++; $display("FAIL local_reg05: got %h want c3", o_rd_data); end
        @(negedge i_clock);
        spi_frame(16'h8500, 16, 1'b0, 7'h0, 8'h0);
        n_cmp++; if (f_rx !== 16'h00C3) begin n_bad++; $display("FAIL local_spi_read: got %h want 00c3", f_rx); end
    endtask

    task automatic test_enable();
        i_enable = 1'b0;
        spi_frame(16'h0277, 16, 1'b0, 7'h0, 8'h0);
        peek(7'h02);
        n_cmp++; if (cnt_strobe - s_strobe + cnt_done - s_done + cnt_err - s_err !== 0) begin n_bad++; $display("FAIL dis_pulses: got %0d want 0", cnt_strobe - s_strobe + cnt_done - s_done + cnt_err - s_err); end
        n_cmp++; if (f_oe !== 1'b0 || f_busy_mid !== 1'b0) begin n_bad++; $display("FAIL dis_oe_busy: got %b%b want 00", f_oe, f_busy_mid); end
        n_cmp++; if (o_rd_data !== 8'h00) begin n_bad++; $display("FAIL dis_reg02: got %h want 00", o_rd_data); end
        i_enable = 1'b1;
        spi_frame(16'h0277, 16, 1'b0, 7'h0, 8'h0);
        peek(7'h02);
        n_cmp++; if (o_rd_data !== 8'h77) begin n_bad++; $display("FAIL en_reg02: got %h want 77", o_rd_data); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] w;
        bit busy_seen;
        w = 16'h0A5C;
        busy_seen = 1'b0;
        snap();
        CS = 1'b0;
        for (int i = 0; i < 5; i++) begin
            MOSI = w[15-i];
            repeat (HALF) @(negedge i_clock);
            SCLK = 1'b1;
            repeat (HALF) @(negedge i_clock);
            SCLK = 1'b0;
        end
        n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b want 1", o_busy); end
        i_reset = 1'b1;
        #1;
        n_cmp++; if (o_busy !== 1'b0 || o_miso_oe !== 1'b0 || MISO !== 1'b0) begin n_bad++; $display("FAIL rstmid_async: got busy %b oe %b miso %b want 0 0 0", o_busy, o_miso_oe, MISO); end
        peek(7'h0A);
        n_cmp++; if (o_rd_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_reg0a: got %h want 00", o_rd_data); end
        peek(7'h05);
        n_cmp++; if (o_rd_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_reg05: got %h want 00", o_rd_data); end
        n_cmp++; if ({o_wr_addr, o_wr_data} !== 15'h0) begin n_bad++; $display("FAIL rstmid_wr: got %h/%h want 00/00", o_wr_addr, o_wr_data); end
        repeat (3) @(negedge i_clock);
        i_reset = 1'b0;
        repeat (6) @(negedge i_clock);
        for (int i = 0; i < 16; i++) begin
            MOSI = w[15-i];
            repeat (HALF) @(negedge i_clock);
            busy_seen = busy_seen | o_busy;
            SCLK = 1'b1;
            repeat (HALF) @(negedge i_clock);
            SCLK = 1'b0;
        end
        repeat (HALF) @(negedge i_clock);
        CS = 1'b1;
        repeat (12) @(negedge i_clock);
        peek(7'h0A);
        n_cmp++; if (cnt_strobe - s_strobe + cnt_done - s_done + cnt_err - s_err !== 0) begin n_bad++; $display("FAIL rstmid_pulses: got %0d want 0", cnt_strobe - s_strobe + cnt_done - s_done + cnt_err - s_err); end
        n_cmp++; if (busy_seen !== 1'b0 || o_rd_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_ignored: got busy %b reg %h want 0 00", busy_seen, o_rd_data); end
        spi_frame(16'h0A5C, 16, 1'b0, 7'h0, 8'h0);
        peek(7'h0A);
        n_cmp++; if (cnt_strobe - s_strobe !== 1 || o_rd_data !== 8'h5C) begin n_bad++; $display("FAIL rstmid_recover: got strobe %0d reg %h want 1 5c", cnt_strobe - s_strobe, o_rd_data); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_readback();
        test_out_of_range();
        test_abort();
        test_collision();
        test_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
